// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : button_debouncer
//  Description : Two-flop synchronizer followed by a four-state qualification
//                FSM.  A new input level is accepted only after the
//                synchronized input has held that level for DEBOUNCE_CYCLES+1
//                consecutive clock edges.  Accepted transitions update
//                level_out and raise a one-cycle rise_out or fall_out pulse.
//                busy_out is high while a candidate transition is pending.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic level_in,
   output logic level_out,
   output logic rise_out,
   output logic fall_out,
   output logic busy_out
);

   // The counter only has to reach DEBOUNCE_CYCLES-1; the +1 keeps the width
   // at least one bit when DEBOUNCE_CYCLES is 1.
   localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      PEND_HI   = 2'd1,
      STABLE_HI = 2'd2,
      PEND_LO   = 2'd3
   } state_t;

   logic             sync1;
   logic             sync2;
   state_t           state;
   logic [CNT_W-1:0] cnt;

   // Two-flop synchronizer: only sync2 is ever looked at by the FSM.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= level_in;
         sync2 <= sync1;
      end
   end

   // Qualification FSM with all outputs registered alongside the state, so
   // busy_out tracks the PEND states exactly and pulses last one cycle.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state     <= STABLE_LO;
         cnt       <= '0;
         level_out <= 1'b0;
         rise_out  <= 1'b0;
         fall_out  <= 1'b0;
         busy_out  <= 1'b0;
      end else begin
         // Pulses are one cycle wide unless an acceptance below re-asserts.
         rise_out <= 1'b0;
         fall_out <= 1'b0;
         case (state)
            STABLE_LO: begin
               if (sync2) begin
                  state    <= PEND_HI;
                  cnt      <= '0;
                  busy_out <= 1'b1;
               end
            end
            PEND_HI: begin
               if (!sync2) begin
                  // Glitch: drop the partial count entirely.
                  state    <= STABLE_LO;
                  cnt      <= '0;
                  busy_out <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state     <= STABLE_HI;
                  cnt       <= '0;
                  level_out <= 1'b1;
                  rise_out  <= 1'b1;
                  busy_out  <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            STABLE_HI: begin
               if (!sync2) begin
                  state    <= PEND_LO;
                  cnt      <= '0;
                  busy_out <= 1'b1;
               end
            end
            PEND_LO: begin
               if (sync2) begin
                  state    <= STABLE_HI;
                  cnt      <= '0;
                  busy_out <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state     <= STABLE_LO;
                  cnt       <= '0;
                  level_out <= 1'b0;
                  fall_out  <= 1'b1;
                  busy_out  <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state     <= STABLE_LO;
               cnt       <= '0;
               level_out <= 1'b0;
               busy_out  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_debouncer
//  Description : Self-checking bench for button_debouncer.  Directed vector
//                table, hand-written corner sequences and a randomized
//                bounce run compared against a run-length reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

   localparam int unsigned DC = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic level;
   logic lvl_o, rise_o, fall_o, busy_o;
   logic rst1_n;
   logic level1;
   logic lvl1_o, rise1_o, fall1_o, busy1_o;

   int checks   = 0;
   int failures = 0;

   button_debouncer #(.DEBOUNCE_CYCLES(DC)) u_dut4 (
      .clk_in    (clk),
      .rst_n_in  (rst_n),
      .level_in  (level),
      .level_out (lvl_o),
      .rise_out  (rise_o),
      .fall_out  (fall_o),
      .busy_out  (busy_o)
   );

   button_debouncer #(.DEBOUNCE_CYCLES(1)) u_dut1 (
      .clk_in    (clk),
      .rst_n_in  (rst1_n),
      .level_in  (level1),
      .level_out (lvl1_o),
      .rise_out  (rise1_o),
      .fall_out  (fall1_o),
      .busy_out  (busy1_o)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic lin;
      logic e_lvl;
      logic e_rise;
      logic e_fall;
      logic e_busy;
   } vec_t;

   vec_t vecs [28];

   // Reference model state for the random run.
   logic m_sync1, m_sync2, m_s, m_lvl, m_rise, m_fall, m_busy;
   int   m_run;

   initial begin
      int   fall_cnt, fall_edge, rise_edge, accepts, hold;
      logic pat [10];
      logic l2, l3, r3;

      // Edge-by-edge expectations for DEBOUNCE_CYCLES=4: clean rise, clean
      // fall, then a 3-cycle glitch that is rejected (s high on three edges,
      // so PEND_HI is occupied for three cycles without acceptance).
      vecs = '{
         '{1'b1,1'b0,1'b0,1'b0,1'b0}, '{1'b1,1'b0,1'b0,1'b0,1'b0},
         '{1'b1,1'b0,1'b0,1'b0,1'b1}, '{1'b1,1'b0,1'b0,1'b0,1'b1},
         '{1'b1,1'b0,1'b0,1'b0,1'b1}, '{1'b1,1'b0,1'b0,1'b0,1'b1},
         '{1'b1,1'b1,1'b1,1'b0,1'b0}, '{1'b1,1'b1,1'b0,1'b0,1'b0},
         '{1'b1,1'b1,1'b0,1'b0,1'b0}, '{1'b0,1'b1,1'b0,1'b0,1'b0},
         '{1'b0,1'b1,1'b0,1'b0,1'b0}, '{1'b0,1'b1,1'b0,1'b0,1'b1},
         '{1'b0,1'b1,1'b0,1'b0,1'b1}, '{1'b0,1'b1,1'b0,1'b0,1'b1},
         '{1'b0,1'b1,1'b0,1'b0,1'b1}, '{1'b0,1'b0,1'b0,1'b1,1'b0},
         '{1'b0,1'b0,1'b0,1'b0,1'b0}, '{1'b0,1'b0,1'b0,1'b0,1'b0},
         '{1'b1,1'b0,1'b0,1'b0,1'b0}, '{1'b1,1'b0,1'b0,1'b0,1'b0},
         '{1'b1,1'b0,1'b0,1'b0,1'b1}, '{1'b0,1'b0,1'b0,1'b0,1'b1},
         '{1'b0,1'b0,1'b0,1'b0,1'b1}, '{1'b0,1'b0,1'b0,1'b0,1'b0},
         '{1'b0,1'b0,1'b0,1'b0,1'b0}, '{1'b0,1'b0,1'b0,1'b0,1'b0},
         '{1'b0,1'b0,1'b0,1'b0,1'b0}, '{1'b0,1'b0,1'b0,1'b0,1'b0}
      };
      pat = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};

      // ---------------- reset state, input held high during reset --------
      rst_n  = 1'b0;
      rst1_n = 1'b0;
      level  = 1'b1;
      level1 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_level", lvl_o, 0);
      check("rst_rise",  rise_o, 0);
      check("rst_fall",  fall_o, 0);
      check("rst_busy",  busy_o, 0);
      check("rst1_level", lvl1_o, 0);
      level  = 1'b0;
      level1 = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // ---------------- directed vector table ----------------------------
      for (int i = 0; i < 28; i++) begin
         level = vecs[i].lin;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_level", i), lvl_o,  vecs[i].e_lvl);
         check($sformatf("vec%0d_rise",  i), rise_o, vecs[i].e_rise);
         check($sformatf("vec%0d_fall",  i), fall_o, vecs[i].e_fall);
         check($sformatf("vec%0d_busy",  i), busy_o, vecs[i].e_busy);
      end

      // ---------------- bounce during PEND_LO ----------------------------
      level = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("bounce_pre_level", lvl_o, 1);
      fall_cnt  = 0;
      fall_edge = -1;
      for (int k = 0; k < 22; k++) begin
         level = (k < 10) ? pat[k] : 1'b0;
         @(posedge clk);
         #1;
         if (rise_o && fall_o) check("bounce_rise_fall_overlap", 1, 0);
         if (fall_o) begin
            fall_cnt++;
            fall_edge = k;
         end
      end
      // Final 1->0 step is sampled on edge 3, accepted 6 edges later.
      check("bounce_fall_count", fall_cnt, 1);
      check("bounce_fall_edge",  fall_edge, 9);
      check("bounce_post_level", lvl_o, 0);

      // ---------------- async reset during PEND_LO -----------------------
      level = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("pendlo_pre_level", lvl_o, 1);
      level = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("pendlo_busy",  busy_o, 1);
      check("pendlo_level", lvl_o, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_level", lvl_o, 0);
      check("async_rst_rise",  rise_o, 0);
      check("async_rst_fall",  fall_o, 0);
      check("async_rst_busy",  busy_o, 0);
      // Reset release with the input already high: normal rise latency.
      level = 1'b1;
      @(posedge clk);
      #1;
      check("in_rst_fall", fall_o, 0);
      #2;
      rst_n     = 1'b1;
      rise_edge = -1;
      fall_cnt  = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         if (fall_o) fall_cnt++;
         if (rise_o && rise_edge < 0) rise_edge = k;
      end
      check("post_rst_no_fall",   fall_cnt, 0);
      check("post_rst_rise_edge", rise_edge, 6);
      check("post_rst_level",     lvl_o, 1);

      // ---------------- DEBOUNCE_CYCLES = 1 ------------------------------
      level1 = 1'b0;
      #2;
      rst1_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      level1 = 1'b1;
      l2 = 1'b1;
      l3 = 1'b0;
      r3 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         if (k == 2) l2 = lvl1_o;
         if (k == 3) begin
            l3 = lvl1_o;
            r3 = rise1_o;
         end
      end
      check("dc1_level_edge2", l2, 0);
      check("dc1_level_edge3", l3, 1);
      check("dc1_rise_edge3",  r3, 1);

      // ---------------- random bounce vs reference model -----------------
      level = 1'b0;
      #2;
      rst_n = 1'b0;
      @(posedge clk);
      #2;
      rst_n   = 1'b1;
      m_sync1 = 1'b0;
      m_sync2 = 1'b0;
      m_lvl   = 1'b0;
      m_rise  = 1'b0;
      m_fall  = 1'b0;
      m_busy  = 1'b0;
      m_run   = 0;
      hold    = 0;
      accepts = 0;
      for (int c = 0; c < 10000; c++) begin
         if (hold == 0) begin
            level = ~level;
            hold  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 12))
                                                : int'($urandom_range(1, 4));
         end
         hold--;
         @(posedge clk);
         // Model: accept once s has differed from the accepted level for
         // DC+1 consecutive edges.
         m_s = m_sync2;
         m_rise = 1'b0;
         m_fall = 1'b0;
         if (m_s != m_lvl) begin
            m_run++;
            if (m_run == DC + 1) begin
               m_lvl  = m_s;
               m_rise = m_s;
               m_fall = ~m_s;
               m_run  = 0;
               accepts++;
            end
         end else begin
            m_run = 0;
         end
         m_busy  = (m_run != 0);
         m_sync2 = m_sync1;
         m_sync1 = level;
         #1;
         if (lvl_o != m_lvl)   check($sformatf("rnd%0d_level", c), lvl_o, m_lvl);
         else checks++;
         if (rise_o != m_rise) check($sformatf("rnd%0d_rise", c), rise_o, m_rise);
         else checks++;
         if (fall_o != m_fall) check($sformatf("rnd%0d_fall", c), fall_o, m_fall);
         else checks++;
         if (busy_o != m_busy) check($sformatf("rnd%0d_busy", c), busy_o, m_busy);
         else checks++;
         if (rise_o && fall_o) check($sformatf("rnd%0d_overlap", c), 1, 0);
      end
      check("rnd_had_accepts", (accepts > 10) ? 1 : 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
